kw_rol_seq: RTL and testbench

//  Multi-cycle rotator: rotates a WIDTH-bit word left or right by a runtime

---
 rtl/kw_rol_seq.sv | 137 +++++++++++++
 tb/tb_kw_rol_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/kw_rol_seq.sv
// kw_rol_seq: multi-cycle word rotator with valid/ready on both sides.
// A request is latched in IDLE. ROT then applies one fixed rotate-left
// stage of 2**step per cycle for every step. DONE holds the result until
// the consumer takes it. Right rotates are folded into an equivalent left
// amount at accept time, so the datapath only ever rotates left.
module kw_rol_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  // Step counter only needs to index the SHW amount bits.
  localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  state_t           r_state;
  logic [STW-1:0]   r_step;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_amt;
  logic             r_err;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  logic [SHW:0]     w_amt_ext;
  logic             w_amt_oor;
  logic [SHW-1:0]   w_amt_eff;
  logic [SHW:0]     w_sh;
  logic [SHW:0]     w_shr;
  logic [WIDTH-1:0] w_rot;
  logic             w_bit;
  logic             w_last;

  // One extra bit so the amount can be compared against WIDTH itself.
  assign w_amt_ext = {1'b0, in_amt};
  assign w_amt_oor = (w_amt_ext >= (SHW+1)'(WIDTH));

  // Fold direction into a left amount; right by 0 stays 0, out-of-range gives 0.
  always_comb begin
    w_amt_eff = '0;
    if (!w_amt_oor) begin
      if (!in_dir) begin
        w_amt_eff = in_amt;
      end else if (in_amt != '0) begin
        w_amt_eff = SHW'((SHW+1)'(WIDTH) - w_amt_ext);
      end
    end
  end

  // Current stage: rotate left by 2**step. 2**step < WIDTH for every step,
  // so both shift distances stay in range even for non-power-of-two WIDTH.
  assign w_sh   = (SHW+1)'(1) << r_step;
  assign w_shr  = (SHW+1)'(WIDTH) - w_sh;
  assign w_rot  = (r_data << w_sh) | (r_data >> w_shr);
  assign w_bit  = r_amt[r_step];
  assign w_last = (r_step == STW'(SHW - 1));

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_data      <= '0;
      r_amt       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_amt      <= w_amt_eff;
            r_err      <= w_amt_oor;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ROT;
          end
        end
        ROT: begin
          if (w_bit) begin
            r_data <= w_rot;
          end
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_bit ? w_rot : r_data;
            r_out_err   <= r_err;
            r_state     <= DONE;
          end else begin
            r_step <= r_step + STW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_err   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_kw_rol_seq.sv
// Testbench for kw_rol_seq: three instances (WIDTH 8, 12, 32) share the clock
// and reset. Directed table vectors, reset-abort sequence, then a random sweep
// checked against a double-word rotate model.
module tb_kw_rol_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  iv, idr, ordy;
  logic [2:0]  ir, ov, oe;
  logic [31:0] id [3];
  logic [4:0]  ia [3];
  logic [7:0]  od8;
  logic [11:0] od12;
  logic [31:0] od32;
  logic [31:0] od [3];

  assign od[0] = {24'd0, od8};
  assign od[1] = {20'd0, od12};
  assign od[2] = od32;

  int WV [3] = '{8, 12, 32};
  int SV [3] = '{3, 4, 5};

  int n_cmp = 0;
  int n_bad = 0;

  kw_rol_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0][7:0]), .in_amt(ia[0][2:0]), .in_dir(idr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od8), .out_err(oe[0]));

  kw_rol_seq #(.WIDTH(12)) u_w12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1][11:0]), .in_amt(ia[1][3:0]), .in_dir(idr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od12), .out_err(oe[1]));

  kw_rol_seq #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .in_amt(ia[2]), .in_dir(idr[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od32), .out_err(oe[2]));

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          amt;
    bit          dir;
    int          hold;
    logic [31:0] ed;
    bit          ee;
  } vec_t;

  vec_t tv [10];

  // Reference: take the top w bits of the doubled word shifted left.
  function automatic logic [31:0] ref_rot(logic [31:0] a, int amt, bit dir,
                                          int w, output bit err);
    logic [63:0] mask, x;
    int l;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, a} & mask;
    if (amt >= w) begin
      err = 1'b1;
      return x[31:0];
    end
    err = 1'b0;
    l = dir ? ((w - amt) % w) : amt;
    x = (x << w) | x;
    x = x << l;
    x = (x >> w) & mask;
    return x[31:0];
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One full transaction: accept, latency, result, optional stall, handshake.
  task automatic op(int i, logic [31:0] data, int amt, bit dir, int hold,
                    logic [31:0] ed, bit ee);
    int n;
    @(negedge clk);
    chk("in_ready_idle", 32'(ir[i]), 32'd1);
    iv[i] = 1'b1; id[i] = data; ia[i] = 5'(amt); idr[i] = dir; ordy[i] = 1'b0;
    @(negedge clk);
    iv[i] = 1'b0; id[i] = $urandom; ia[i] = 5'($urandom); idr[i] = 1'($urandom);
    chk("busy_in_ready", 32'(ir[i]), 32'd0);
    n = 0;
    while (!ov[i] && n < 40) begin
      @(negedge clk);
      n++;
      id[i] = $urandom;
      ia[i] = 5'($urandom);
    end
    chk("latency", 32'(n), 32'(SV[i]));
    chk("out_data", od[i], ed);
    chk("out_err", 32'(oe[i]), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      iv[i] = 1'b1; id[i] = $urandom; ia[i] = 5'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(ov[i]), 32'd1);
      chk("hold_data", od[i], ed);
      chk("hold_in_ready", 32'(ir[i]), 32'd0);
    end
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0; iv[i] = 1'b0;
    chk("post_valid", 32'(ov[i]), 32'd0);
    chk("post_in_ready", 32'(ir[i]), 32'd1);
    chk("post_data", od[i], 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, e;
    int a, inst, hold;
    bit dr, er;

    tv[0] = '{0, 32'hA5,       3,  1'b0, 0, 32'h2D,       1'b0};
    tv[1] = '{0, 32'h01,       1,  1'b1, 0, 32'h80,       1'b0};
    tv[2] = '{0, 32'h01,       0,  1'b1, 0, 32'h01,       1'b0};
    tv[3] = '{1, 32'h123,      4,  1'b0, 0, 32'h231,      1'b0};
    tv[4] = '{1, 32'h123,      12, 1'b0, 0, 32'h123,      1'b1};
    tv[5] = '{0, 32'h81,       7,  1'b0, 5, 32'hC0,       1'b0};
    tv[6] = '{2, 32'h12345678, 8,  1'b1, 1, 32'h78123456, 1'b0};
    tv[7] = '{2, 32'h80000001, 31, 1'b0, 0, 32'hC0000000, 1'b0};
    tv[8] = '{1, 32'hABC,      5,  1'b1, 2, 32'hE55,      1'b0};
    tv[9] = '{1, 32'hABC,      15, 1'b1, 0, 32'hABC,      1'b1};

    rst_n = 1'b0;
    iv = '0; idr = '0; ordy = '0;
    for (int i = 0; i < 3; i++) begin
      id[i] = '0;
      ia[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", 32'(ir[i]), 32'd1);
      chk("reset_valid", 32'(ov[i]), 32'd0);
      chk("reset_data", od[i], 32'd0);
      chk("reset_err", 32'(oe[i]), 32'd0);
    end
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      op(tv[k].inst, tv[k].data, tv[k].amt, tv[k].dir, tv[k].hold,
         tv[k].ed, tv[k].ee);
    end

    // Abort mid-ROT with reset, then a fresh request must complete.
    @(negedge clk);
    iv[2] = 1'b1; id[2] = 32'hDEADBEEF; ia[2] = 5'd9; idr[2] = 1'b0;
    @(negedge clk);
    iv[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(ov[2]), 32'd0);
    chk("abort_in_ready", 32'(ir[2]), 32'd1);
    chk("abort_data", od[2], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(2, 32'hDEADBEEF, 4, 1'b1, 0, 32'hFDEADBEE, 1'b0);

    for (int k = 0; k < 200; k++) begin
      inst = int'($urandom_range(2, 0));
      d    = $urandom;
      a    = int'($urandom_range((1 << SV[inst]) - 1, 0));
      dr   = 1'($urandom);
      hold = int'($urandom_range(3, 0));
      e    = ref_rot(d, a, dr, WV[inst], er);
      op(inst, d, a, dr, hold, e, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
